// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multicycle MIPS main controller: state encoding,
// opcodes, datapath select encodings and the control bundle.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXEC,
    ALUWB,
    IEXEC,
    IWB,
    BRANCH,
    JUMP,
    HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_FUNCT = 3'b100;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       extop;
    logic [2:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  // Zero-extended immediates for the logical ops, sign-extended otherwise.
  function automatic logic is_logic_imm(input logic [5:0] op);
    return (op == OP_ORI) || (op == OP_ANDI);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath/memory bundle; master is the controller side.
interface mc_ctrl_fsm_if;

  logic [5:0] op;
  logic       zero;
  logic       mem_ready;

  logic       mem_req;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       pcen;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       extop;
  logic [2:0] aluop;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, zero, mem_ready,
    output mem_req, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
           extop, aluop, regdst, memtoreg, regwrite, instr_done, illegal
  );

  modport slave (
    output op, zero, mem_ready,
    input  mem_req, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
           extop, aluop, regdst, memtoreg, regwrite, instr_done, illegal
  );

endinterface

// File: rtl/mc_ctrl_outdec.sv
// State/opcode to control-bundle decode; purely combinational, Moore except
// pcen/irwrite, which follow mem_ready in FETCH and zero in BRANCH.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALU_ADD;
        ctrl.pcsrc   = PC_ALU;
        ctrl.irwrite = mem_ready;
        ctrl.pcen    = mem_ready;
      end
      DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALU_ADD;
      end
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALU_ADD;
      end
      MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEMWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.memtoreg   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEMWR: begin
        // Strobe held for every cycle; the store retires on the ready cycle.
        ctrl.mem_req    = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.memwrite   = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REGB;
        ctrl.aluop   = ALU_FUNCT;
      end
      ALUWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.regdst     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      IEXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.extop   = is_logic_imm(op);
        if (op == OP_ORI)
          ctrl.aluop = ALU_OR;
        else if (op == OP_ANDI)
          ctrl.aluop = ALU_AND;
        else
          ctrl.aluop = ALU_ADD;
      end
      IWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl.alusrca    = 1'b1;
        ctrl.alusrcb    = SRCB_REGB;
        ctrl.aluop      = ALU_SUB;
        ctrl.pcsrc      = PC_ALUOUT;
        ctrl.instr_done = 1'b1;
        ctrl.pcen       = (op == OP_BNE) ? ~zero : zero;
      end
      JUMP: begin
        ctrl.pcsrc      = PC_JUMP;
        ctrl.pcen       = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      HALT: begin
        ctrl.illegal = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main controller; one state per datapath step, memory
// states stall on mem_ready, illegal opcodes park in HALT until reset.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  mc_ctrl_fsm_if.master bus
);

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   state_nxt = FETCH;
      FETCH:  if (bus.mem_ready) state_nxt = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW:             state_nxt = MEMADR;
          OP_RTYPE:                 state_nxt = EXEC;
          OP_ADDI, OP_ORI, OP_ANDI: state_nxt = IEXEC;
          OP_BEQ, OP_BNE:           state_nxt = BRANCH;
          OP_J:                     state_nxt = JUMP;
          default:                  state_nxt = HALT;
        endcase
      end
      MEMADR: state_nxt = (bus.op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (bus.mem_ready) state_nxt = MEMWB;
      MEMWB:  state_nxt = FETCH;
      MEMWR:  if (bus.mem_ready) state_nxt = FETCH;
      EXEC:   state_nxt = ALUWB;
      ALUWB:  state_nxt = FETCH;
      IEXEC:  state_nxt = IWB;
      IWB:    state_nxt = FETCH;
      BRANCH: state_nxt = FETCH;
      JUMP:   state_nxt = FETCH;
      HALT:   state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state     (state),
    .op        (bus.op),
    .zero      (bus.zero),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  always_comb begin
    bus.mem_req    = ctrl.mem_req;
    bus.iord       = ctrl.iord;
    bus.memwrite   = ctrl.memwrite;
    bus.irwrite    = ctrl.irwrite;
    bus.pcen       = ctrl.pcen;
    bus.pcsrc      = ctrl.pcsrc;
    bus.alusrca    = ctrl.alusrca;
    bus.alusrcb    = ctrl.alusrcb;
    bus.extop      = ctrl.extop;
    bus.aluop      = ctrl.aluop;
    bus.regdst     = ctrl.regdst;
    bus.memtoreg   = ctrl.memtoreg;
    bus.regwrite   = ctrl.regwrite;
    bus.instr_done = ctrl.instr_done;
    bus.illegal    = ctrl.illegal;
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench: a per-instruction cycle model pushes expected control
// vectors; a negedge monitor pops and compares every DUT cycle.
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       extop;
    logic [2:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       instr_done;
    logic       illegal;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  mc_ctrl_fsm_if bus();

  mc_ctrl_fsm dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   cut_left;
  bit   aborted;

  function automatic bit is_legal(input logic [5:0] o);
    return o inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_ORI, OP_ANDI};
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.mem_req = bus.mem_req;   a.iord = bus.iord;         a.memwrite = bus.memwrite;
    a.irwrite = bus.irwrite;   a.pcen = bus.pcen;         a.pcsrc = bus.pcsrc;
    a.alusrca = bus.alusrca;   a.alusrcb = bus.alusrcb;   a.extop = bus.extop;
    a.aluop = bus.aluop;       a.regdst = bus.regdst;     a.memtoreg = bus.memtoreg;
    a.regwrite = bus.regwrite; a.instr_done = bus.instr_done; a.illegal = bus.illegal;
    return a;
  endfunction

  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    cyc++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = sample();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL ctrl cyc=%0d act=%b exp=%b (order mem_req iord memwrite irwrite pcen pcsrc alusrca alusrcb extop aluop regdst memtoreg regwrite instr_done illegal)",
                 cyc, a, e);
      end
    end
  end

  task automatic cycle(input obs_t v, input logic mr, input logic [5:0] o,
                       input logic z, input logic r);
    @(posedge clk);
    #1;
    reset         = r;
    bus.op        = o;
    bus.zero      = z;
    bus.mem_ready = mr;
    exp_q.push_back(v);
  endtask

  task automatic step(input obs_t v, input logic mr, input logic [5:0] o, input logic z);
    if (aborted) return;
    if (cut_left == 0) begin
      aborted = 1'b1;
      cycle('0, 1'($urandom), o, 1'($urandom), 1'b1);
      return;
    end
    cut_left--;
    cycle(v, mr, o, z, 1'b0);
  endtask

  // Two reset cycles then one idle cycle with reset released.
  task automatic reset_seq();
    cycle('0, 1'($urandom), 6'($urandom), 1'($urandom), 1'b1);
    cycle('0, 1'($urandom), 6'($urandom), 1'($urandom), 1'b1);
    cycle('0, 1'($urandom), 6'($urandom), 1'($urandom), 1'b0);
  endtask

  // One instruction from FETCH to its last cycle. wf/wm are wait-states in
  // FETCH and in the data access; cut is the cycle index where reset hits.
  task automatic do_instr(input logic [5:0] o, input logic z, input int wf,
                          input int wm, input int cut, input int halt_n);
    obs_t v;
    cut_left = cut;
    aborted  = 1'b0;
    for (int i = 0; i < wf; i++) begin
      v = '0; v.mem_req = 1; v.alusrcb = 2'b01;
      step(v, 1'b0, 6'($urandom), 1'($urandom));
    end
    v = '0; v.mem_req = 1; v.alusrcb = 2'b01; v.irwrite = 1; v.pcen = 1;
    step(v, 1'b1, 6'($urandom), 1'($urandom));
    v = '0; v.alusrcb = 2'b11;
    step(v, 1'($urandom), o, 1'($urandom));
    if (!is_legal(o)) begin
      for (int i = 0; i < halt_n; i++) begin
        v = '0; v.illegal = 1;
        step(v, 1'($urandom), o, 1'($urandom));
      end
    end else if (o == OP_LW || o == OP_SW) begin
      v = '0; v.alusrca = 1; v.alusrcb = 2'b10;
      step(v, 1'($urandom), o, 1'($urandom));
      for (int i = 0; i <= wm; i++) begin
        v = '0; v.mem_req = 1; v.iord = 1;
        if (o == OP_SW) begin
          v.memwrite = 1;
          v.instr_done = (i == wm);
        end
        step(v, (i == wm), o, 1'($urandom));
      end
      if (o == OP_LW) begin
        v = '0; v.regwrite = 1; v.memtoreg = 1; v.instr_done = 1;
        step(v, 1'($urandom), o, 1'($urandom));
      end
    end else if (o == OP_RTYPE) begin
      v = '0; v.alusrca = 1; v.aluop = 3'b100;
      step(v, 1'($urandom), o, 1'($urandom));
      v = '0; v.regwrite = 1; v.regdst = 1; v.instr_done = 1;
      step(v, 1'($urandom), o, 1'($urandom));
    end else if (o == OP_ADDI || o == OP_ORI || o == OP_ANDI) begin
      v = '0; v.alusrca = 1; v.alusrcb = 2'b10;
      v.aluop = (o == OP_ORI) ? 3'b010 : (o == OP_ANDI) ? 3'b011 : 3'b000;
      v.extop = (o != OP_ADDI);
      step(v, 1'($urandom), o, 1'($urandom));
      v = '0; v.regwrite = 1; v.instr_done = 1;
      step(v, 1'($urandom), o, 1'($urandom));
    end else if (o == OP_BEQ || o == OP_BNE) begin
      v = '0; v.alusrca = 1; v.aluop = 3'b001; v.pcsrc = 2'b01; v.instr_done = 1;
      v.pcen = (o == OP_BEQ) ? z : !z;
      step(v, 1'($urandom), o, z);
    end else begin
      v = '0; v.pcsrc = 2'b10; v.pcen = 1; v.instr_done = 1;
      step(v, 1'($urandom), o, 1'($urandom));
    end
    if (aborted || !is_legal(o))
      reset_seq();
  endtask

  initial begin
    logic [5:0] ops [9];
    logic [5:0] o;
    int         cut;
    ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_ORI, OP_ANDI};
    bus.op = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    reset_seq();
    do_instr(OP_LW,   1'b0, 0, 0, 1000, 0);
    do_instr(OP_LW,   1'b0, 0, 0, 4,    0);
    do_instr(OP_SW,   1'b0, 0, 3, 1000, 0);
    do_instr(OP_BEQ,  1'b1, 0, 0, 1000, 0);
    do_instr(OP_BNE,  1'b1, 0, 0, 1000, 0);
    do_instr(OP_BEQ,  1'b0, 1, 0, 1000, 0);
    do_instr(OP_BNE,  1'b0, 0, 0, 1000, 0);
    do_instr(OP_ORI,  1'b0, 0, 0, 1000, 0);
    do_instr(OP_ANDI, 1'b0, 0, 0, 1000, 0);
    do_instr(OP_ADDI, 1'b0, 2, 0, 1000, 0);
    do_instr(OP_RTYPE,1'b0, 0, 0, 1000, 0);
    do_instr(OP_J,    1'b0, 0, 0, 1000, 0);
    do_instr(6'b111111, 1'b0, 0, 0, 1000, 20);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) < 18)
        o = ops[$urandom_range(0, 8)];
      else
        o = 6'($urandom);
      cut = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 6)) : 1000;
      do_instr(o, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               cut, int'($urandom_range(1, 5)));
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multicycle main controller for the MIPS core. It sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback steps. It supports the same opcode set as the single-cycle decoder: RTYPE, LW, SW, BEQ, BNE, ADDI, J, ORI and ANDI. It drives every datapath mux select and write enable, waits on a memory ready handshake, and traps on illegal opcodes.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces state IDLE immediately.
- op  in  6  opcode from instruction register; stable from DECODE until the next FETCH.
- zero  in  1  ALU zero flag; sampled combinationally in BRANCH.
- mem_ready  in  1  memory completed the current access this cycle.
- mem_req  out  1  memory access request.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction register load.
- pcen  out  1  PC load enable.
- pcsrc  out  2  next PC: 00 ALU result, 01 ALUOut (branch target), 10 jump target.
- alusrca  out  1  ALU A: 0 = PC, 1 = regA.
- alusrcb  out  2  ALU B: 00 regB, 01 constant 4, 10 extended imm, 11 sign imm<<2.
- extop  out  1  immediate extension: 0 = sign, 1 = zero.
- aluop  out  3  000 add, 001 sub, 010 or, 011 and, 100 use funct.
- regdst  out  1  write register select: 1 = rd, 0 = rt.
- memtoreg  out  1  write data select: 1 = memory data, 0 = ALUOut.
- regwrite  out  1  register file write.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- illegal  out  1  sticky; high in HALT.

## Operation
- Moore outputs decode from state. The exception is pcen in FETCH and BRANCH, which also depends on mem_ready or zero. Every output not listed for a state is 0.
- IDLE: all outputs 0. Goes to FETCH unconditionally.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=000, pcsrc=00. irwrite=pcen=mem_ready. Holds until mem_ready, then goes to DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=000, which computes the branch target into ALUOut. Next state by op:
  - LW or SW → MEMADR.
  - RTYPE → EXEC.
  - ADDI, ORI or ANDI → IEXEC.
  - BEQ or BNE → BRANCH.
  - J → JUMP.
  - any other opcode → HALT.
- MEMADR: alusrca=1, alusrcb=10, extop=0, aluop=000. LW → MEMRD; SW → MEMWR.
- MEMRD: mem_req=1, iord=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0, instr_done=1. Goes to FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1. Holds until mem_ready. In the mem_ready cycle, instr_done=1 and next state is FETCH.
- EXEC: alusrca=1, alusrcb=00, aluop=100. Goes to ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0, instr_done=1. Goes to FETCH.
- IEXEC: alusrca=1, alusrcb=10.
  - ADDI: aluop=000, extop=0.
  - ORI: aluop=010, extop=1.
  - ANDI: aluop=011, extop=1.
  - Goes to IWB.
- IWB: regwrite=1, regdst=0, memtoreg=0, instr_done=1. Goes to FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=001, pcsrc=01, instr_done=1. pcen=zero for BEQ, pcen=~zero for BNE. Goes to FETCH.
- JUMP: pcsrc=10, pcen=1, instr_done=1. Goes to FETCH.
- HALT: illegal=1, all other outputs 0. Remains in HALT until reset.

## Timing
- Reset asserted: state IDLE asynchronously; every output is 0, including illegal.
- First FETCH is the cycle after the first clock edge with reset low.
- With mem_ready tied high, cycles per instruction (FETCH to last cycle inclusive):
  - LW 5; SW 4; RTYPE 4; ADDI, ORI, ANDI 4; BEQ, BNE 3; J 3.
- Each wait-state cycle (mem_ready=0 in FETCH, MEMRD or MEMWR) adds exactly one cycle. Outputs stay constant during the wait, except that pcen and irwrite stay 0.
- memwrite stays asserted for every MEMWR cycle; memory commits only on the mem_ready cycle.
- Reset mid-instruction: the next cycle has all outputs 0, with no partial regwrite or pcen. The interrupted instruction is abandoned.
- instr_done never fires in IDLE, FETCH, DECODE or HALT. The instruction that lands in HALT produces no instr_done.

## Structure
- Package mc_ctrl_pkg holds:
  - state_t enum: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, IEXEC, IWB, BRANCH, JUMP, HALT.
  - Opcode localparams (OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100, OP_BNE=000101, OP_ADDI=001000, OP_J=000010, OP_ORI=001101, OP_ANDI=001100).
  - aluop, pcsrc and alusrcb encodings.
- Single module with a state register and combinational next-state and output blocks. Sub-module mc_ctrl_outdec (state, op → control bundle) is optional.

## Test plan
- Reset asserted mid-MEMWB of LW → same cycle regwrite=0, state IDLE. After release, FETCH follows in 1 cycle.
- LW with mem_ready=1 → 5 cycles. Exactly one regwrite with memtoreg=1, regdst=0. instr_done pulses on cycle 5.
- SW with mem_ready low for 3 cycles in MEMWR → memwrite high 4 cycles, instr_done only on the 4th, total 7 cycles.
- BEQ with zero=1 → pcen=1, pcsrc=01 in cycle 3. BNE with zero=1 → pcen=0 in BRANCH.
- ORI → IEXEC aluop=010, extop=1, then IWB regwrite=1, regdst=0. ANDI → aluop=011. ADDI → aluop=000, extop=0.
- Opcode 111111 → DECODE then HALT. illegal=1 and all enables 0 for 20 cycles. Reset clears illegal.
